// File: rtl/alu_multibyte_seq_pkg.sv
// Shared types for the multi-byte ALU sequencer: FSM states, ALU function codes,
// and the legal-function check.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } seq_state_t;

   typedef enum logic [1:0] {
      ADD_FN = 2'b00,
      AND_FN = 2'b01,
      OR_FN  = 2'b10
   } alu_fn_t;

   function automatic logic is_legal_fn(input logic [1:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         2'(ADD_FN), 2'(AND_FN), 2'(OR_FN): legal = 1'b1;
         default:                           legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_multibyte_seq_if.sv
// Request/response bus between the control unit (master) and the multi-byte
// ALU sequencer (slave).
interface alu_multibyte_seq_if #(
   parameter int unsigned NBYTES = 4
);
   localparam int unsigned W = 8 * NBYTES;

   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         req_cin;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] resp_result;
   logic         resp_c;
   logic         resp_z;
   logic         resp_n;
   logic         resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_c, resp_z, resp_n, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
      output req_ready, resp_valid, resp_result, resp_c, resp_z, resp_n, resp_err
   );

endinterface

// File: rtl/alu_multibyte_seq_alu.sv
// Shared 8-bit combinational ALU: ADD with carry, AND, OR.
module alu_multibyte_seq_alu
   import alu_seq_pkg::*;
(
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic       c_in,
   input  alu_fn_t    opcode,
   output logic [7:0] result,
   output logic       c_out
);

   always_comb begin
      result = 8'h00;
      c_out  = 1'b0;
      case (opcode)
         ADD_FN:  {c_out, result} = 9'(in1) + 9'(in2) + 9'(c_in);
         AND_FN:  result = in1 & in2;
         OR_FN:   result = in1 | in2;
         default: result = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_multibyte_seq.sv
// Runs NBYTES-wide ADD/AND/OR through the 8-bit ALU one byte per cycle, LSB first.
// Build option: ALU_SEQ_PIPE_EN allows a new request to be accepted on the edge
// that consumes the current response.
module alu_multibyte_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input logic               clk,
   input logic               rst_n,
   alu_multibyte_seq_if.slave bus
);

   localparam int unsigned W     = 8 * NBYTES;
   localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   seq_state_t       state_q, state_d;
   logic [W-1:0]     a_q, b_q, result_q;
   alu_fn_t          op_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic             resp_valid_q, c_q, z_q, n_q, err_q;

   logic             ready_c, accept_c, legal_c;
   logic [7:0]       alu_in1, alu_in2, alu_res;
   logic             alu_cin, alu_cout;
   alu_fn_t          alu_op;
   logic [IDX_W+2:0] byte_sel;

   assign byte_sel = {idx_q, 3'b000};
   assign legal_c  = is_legal_fn(bus.req_op);

   // Request acceptance; in DONE only possible in the pipelined build
   always_comb begin
      ready_c = 1'b0;
      case (state_q)
         IDLE: ready_c = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
         DONE: ready_c = resp_valid_q & bus.resp_ready;
`else
         DONE: ready_c = 1'b0;
`endif
         default: ready_c = 1'b0;
      endcase
   end

   assign accept_c = bus.req_valid & ready_c;

   // Next state and ALU operand steering
   always_comb begin
      state_d = state_q;
      alu_in1 = 8'h00;
      alu_in2 = 8'h00;
      alu_cin = 1'b0;
      alu_op  = ADD_FN;
      case (state_q)
         IDLE: begin
            if (accept_c) state_d = legal_c ? BUSY : DONE;
         end
         BUSY: begin
            alu_in1 = a_q[byte_sel +: 8];
            alu_in2 = b_q[byte_sel +: 8];
            alu_cin = carry_q;
            alu_op  = op_q;
            if (idx_q == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            if (accept_c)                          state_d = legal_c ? BUSY : DONE;
            else if (resp_valid_q & bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand capture, byte-serial result assembly, and response flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         op_q         <= ADD_FN;
         carry_q      <= 1'b0;
         idx_q        <= '0;
         resp_valid_q <= 1'b0;
         c_q          <= 1'b0;
         z_q          <= 1'b0;
         n_q          <= 1'b0;
         err_q        <= 1'b0;
      end else if (accept_c) begin
         a_q          <= bus.req_a;
         b_q          <= bus.req_b;
         op_q         <= alu_fn_t'(bus.req_op);
         carry_q      <= bus.req_cin & (bus.req_op == 2'(ADD_FN));
         idx_q        <= '0;
         result_q     <= '0;
         resp_valid_q <= 1'b0;
         c_q          <= 1'b0;
         z_q          <= 1'b0;
         n_q          <= 1'b0;
         err_q        <= ~legal_c;
      end else begin
         case (state_q)
            BUSY: begin
               result_q[byte_sel +: 8] <= alu_res;
               carry_q <= (op_q == ADD_FN) & alu_cout;
               idx_q   <= idx_q + IDX_W'(1);
            end
            DONE: begin
               // Flags come from the fully registered word, one cycle after the last byte
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
                  c_q          <= carry_q;
                  z_q          <= (result_q == '0);
                  n_q          <= result_q[W-1];
               end else if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   alu_multibyte_seq_alu u_alu (
      .in1    (alu_in1),
      .in2    (alu_in2),
      .c_in   (alu_cin),
      .opcode (alu_op),
      .result (alu_res),
      .c_out  (alu_cout)
   );

   assign bus.req_ready   = ready_c;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = result_q;
   assign bus.resp_c      = c_q;
   assign bus.resp_z      = z_q;
   assign bus.resp_n      = n_q;
   assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Directed bench for alu_multibyte_seq with NBYTES=4; covers ALU_SEQ_PIPE_EN when defined.
module tb_alu_multibyte_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_multibyte_seq_if #(.NBYTES(4)) bus ();

   alu_multibyte_seq #(.NBYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input string tag);
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_cin   = cin;
      bus.req_valid = 1'b1;
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int exp_lat, input string tag);
      int n;
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic check_resp(input logic [31:0] res, input logic c, input logic z,
                             input logic n, input logic err, input string tag);
      chk({tag, "_result"}, 64'(bus.resp_result), 64'(res));
      chk({tag, "_cznE"}, 64'({bus.resp_c, bus.resp_z, bus.resp_n, bus.resp_err}),
          64'({c, z, n, err}));
   endtask

   task automatic consume(input string tag);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      chk({tag, "_consumed"}, 64'(bus.resp_valid), 64'd0);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input int lat, input logic [31:0] res,
                      input logic c, input logic z, input logic n, input logic err,
                      input string tag);
      issue(op, a, b, cin, tag);
      wait_resp(lat, tag);
      check_resp(res, c, z, n, err, tag);
      consume(tag);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'b00;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_cin    = 1'b0;
      bus.resp_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_resp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

      run(2'b00, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 5, 32'h0100_0000, 0, 0, 0, 0, "add_ripple");
      run(2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5, 32'h0000_0000, 1, 1, 0, 0, "add_cin_wrap");
      run(2'b01, 32'hF0F0_0F0F, 32'h0F0F_F0F0, 1'b1, 5, 32'h0000_0000, 0, 1, 0, 0, "and_zero");
      run(2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, 5, 32'h8000_0001, 0, 0, 1, 0, "or_neg");
      run(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 5, 32'h0000_0000, 1, 1, 0, 0, "add_msb_ovf");
      run(2'b11, 32'h1234_5678, 32'h1111_1111, 1'b1, 1, 32'h0000_0000, 0, 1, 0, 1, "illegal_op");

      // Response held in DONE while a new request is waiting
      issue(2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, "hold");
      wait_resp(5, "hold");
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b10;
      bus.req_a     = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_valid", 64'(bus.resp_valid), 64'd1);
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
         check_resp(32'h2345_6789, 0, 0, 0, 0, "hold");
      end
      bus.req_valid = 1'b0;
      consume("hold");
      chk("hold_idle_ready", 64'(bus.req_ready), 64'd1);

      // Asynchronous reset during the second BUSY cycle
      issue(2'b00, 32'h0000_00FF, 32'h0000_00FF, 1'b0, "rst_mid");
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_result", 64'(bus.resp_result), 64'd0);
      chk("rst_async_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_async_ready", 64'(bus.req_ready), 64'd1);
      step();
      rst_n = 1'b1;
      repeat (6) step();
      chk("rst_no_resp", 64'(bus.resp_valid), 64'd0);
      run(2'b00, 32'h0000_0001, 32'h0000_0001, 1'b0, 5, 32'h0000_0002, 0, 0, 0, 0, "post_rst_add");

      // Back-to-back requests with resp_ready held high
      bus.resp_ready = 1'b1;
      issue(2'b00, 32'h0000_0010, 32'h0000_0020, 1'b0, "b2b_first");
      bus.req_valid = 1'b1;
      bus.req_a     = 32'h7FFF_FFFF;
      bus.req_b     = 32'h0000_0001;
      wait_resp(5, "b2b_first");
      check_resp(32'h0000_0030, 0, 0, 0, 0, "b2b_first");
`ifdef ALU_SEQ_PIPE_EN
      chk("b2b_pipe_ready", 64'(bus.req_ready), 64'd1);
      step();
      bus.req_valid = 1'b0;
      chk("b2b_pipe_busy_ready", 64'(bus.req_ready), 64'd0);
`else
      chk("b2b_done_ready", 64'(bus.req_ready), 64'd0);
      step();
      chk("b2b_bubble_ready", 64'(bus.req_ready), 64'd1);
      step();
      bus.req_valid = 1'b0;
`endif
      chk("b2b_second_valid", 64'(bus.resp_valid), 64'd0);
      wait_resp(5, "b2b_second");
      check_resp(32'h8000_0000, 0, 0, 1, 0, "b2b_second");
      step();
      bus.resp_ready = 1'b0;
      chk("b2b_end_valid", 64'(bus.resp_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
